uart_bytes_rx: RTL and testbench
================================

Name: uart_bytes_rx

Overview:
- Multi-byte UART receiver: deserialises BYTES consecutive UART frames from uart_rxd into one BYTES*8-bit word.
- Pulses uart_bytes_done when the word is complete.
- Pairs with the multi-byte UART transmitter on the far end of the link. Receives on the link's RX pin and hands complete words to user logic.
- Self-contained: includes bit-level synchroniser, start detection and mid-bit sampling. Frame format is fixed at 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.

Parameters:
- BYTES, 4: bytes per word (>=1).
- BPS, 9_600: baud rate.
- CLK_FRE, 50_000_000: sys_clk frequency in Hz. BAUD_CNT = CLK_FRE/BPS (integer division, >=4). HALF = BAUD_CNT/2.
- TIMEOUT_BITS, 20: inter-byte timeout in bit times. Used only with UART_RX_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock; single clock domain.
- sys_rst_n  in  1  asynchronous, active-low reset.
- uart_rxd  in  1  UART serial input; asynchronous, idles high.
- uart_bytes_data  out  BYTES*8  last complete word. First received byte is in [7:0], last in the top byte. Held until the next complete word.
- uart_bytes_done  out  1  one-cycle pulse; uart_bytes_data is valid in that cycle and after.
- uart_frame_err  out  1  one-cycle pulse on a stop-bit error.
- uart_bytes_timeout  out  1  one-cycle pulse on inter-byte timeout. Port exists only when UART_RX_TIMEOUT_EN is defined.

Behaviour:
- Reset: all outputs 0. State IDLE. Counters, byte shift register and byte_cnt cleared. Synchroniser flops set to 1. Reset is asynchronous and effective mid-frame; any partial word is discarded.
- Input path:
  - uart_rxd passes through 2 synchroniser flops plus 1 edge flop.
  - Start condition: synchronised falling edge (prev=1, cur=0) while in IDLE.
- FSM states: IDLE, START, DATA, STOP. A baud counter clk_cnt restarts at 0 on every state entry and on every sample.
  - IDLE -> START on the start condition.
  - START: sample when clk_cnt==HALF-1. Sample 1 = glitch: go to IDLE with no output. Sample 0: go to DATA with bit_cnt=0.
  - DATA: sample when clk_cnt==BAUD_CNT-1. Shift the sample in LSB first (rx_byte <= {s, rx_byte[7:1]}). After bit_cnt==7 go to STOP.
  - STOP: sample when clk_cnt==BAUD_CNT-1, i.e. mid stop bit. Go to IDLE in every case, so a start edge arriving right after mid-stop is caught.
- Stop sample = 1 (valid byte):
  - word_sr <= {rx_byte, word_sr[BYTES*8-1:8]}.
  - If byte_cnt==BYTES-1: next cycle uart_bytes_data <= assembled word, uart_bytes_done=1 for one cycle, byte_cnt <= 0.
  - Otherwise byte_cnt+1.
- Stop sample = 0 (framing error):
  - Byte discarded, byte_cnt <= 0 (partial word discarded).
  - Next cycle uart_frame_err=1 for one cycle. uart_bytes_data unchanged.
- Latency: uart_bytes_done rises 1 sys_clk after the mid-stop sample of the last byte.
- Back-to-back frames with zero idle time are fully supported.
- uart_frame_err and uart_bytes_done never assert in the same cycle.
- BYTES=1: every valid frame produces a done pulse.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- Defined:
  - An idle counter runs while state==IDLE and byte_cnt!=0, and clears on leaving IDLE.
  - When it reaches TIMEOUT_BITS*BAUD_CNT-1: byte_cnt <= 0, partial word discarded, uart_bytes_timeout pulses for one cycle. uart_bytes_data is unchanged.
- Not defined: no idle counter and no uart_bytes_timeout port. A partial word waits indefinitely for its remaining bytes.

Test Plan:
Bench uses CLK_FRE=50_000_000, BPS=5_000_000 (BAUD_CNT=10), BYTES=4.
- Clean word: send frames 0x34, 0x12, 0xCD, 0xAB -> exactly one done pulse, data=0xABCD1234, frame_err stays 0.
- Glitch: uart_rxd low for 3 cycles, then high -> no state advance beyond START, no pulses. A following word 0x04,0x03,0x02,0x01 -> data=0x01020304.
- Framing error: 2nd frame has stop bit=0 -> one frame_err pulse, no done, data keeps its prior value. Then 0x11,0x22,0x33,0x44 -> data=0x44332211.
- Back-to-back: 8 frames 0x00..0x07 with zero idle -> two done pulses with data=0x03020100, then 0x07060504.
- Reset mid-frame: assert sys_rst_n=0 during DATA of byte 3 -> all outputs 0 immediately. After release, a clean word 0xDEADBEEF (bytes EF,BE,AD,DE) is received correctly.
- Timeout (UART_RX_TIMEOUT_EN): send 2 bytes, idle 25 bit times -> one timeout pulse at 20 bit times, no done. Then 4 bytes A1,B2,C3,D4 -> data=0xD4C3B2A1.

Source files
------------

// File: rtl/uart_bytes_rx.sv
// Multi-byte UART receiver: assembles BYTES consecutive 8N1 frames (LSB first) into one word.
// Optional inter-byte timeout and uart_bytes_timeout port enabled by defining UART_RX_TIMEOUT_EN.
module uart_bytes_rx #(
   parameter int BYTES        = 4,
   parameter int BPS          = 9_600,
   parameter int CLK_FRE      = 50_000_000,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 uart_rxd,
   output logic [BYTES*8-1:0]   uart_bytes_data,
   output logic                 uart_bytes_done,
`ifdef UART_RX_TIMEOUT_EN
   output logic                 uart_bytes_timeout,
`endif
   output logic                 uart_frame_err
);

   localparam int BAUD_CNT = CLK_FRE / BPS;
   localparam int HALF     = BAUD_CNT / 2;
   localparam int CW       = $clog2(BAUD_CNT);
   localparam int BW       = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int WW       = BYTES * 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_rxd_s1;
   logic              r_rxd_s2;
   logic              r_rxd_d;
   logic [CW-1:0]     r_clk_cnt;
   logic [2:0]        r_bit_cnt;
   logic [7:0]        r_rx_byte;
   logic [WW-1:0]     r_word_sr;
   logic [BW-1:0]     r_byte_cnt;
   logic [WW-1:0]     r_data;
   logic              r_done;
   logic              r_err;
   logic              w_sample;
   logic              w_start_edge;
   logic              w_stop_ok;
   logic              w_stop_bad;
   logic              w_last_byte;
   logic              w_timeout;
   logic [WW-1:0]     w_word_next;

   if (BYTES < 1 || BAUD_CNT < 4 || TIMEOUT_BITS < 1) begin : g_param_check
      $error("uart_bytes_rx: invalid parameter set");
   end

   // Two-flop synchroniser plus one flop of history for falling-edge detection.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rxd_s1 <= 1'b1;
         r_rxd_s2 <= 1'b1;
         r_rxd_d  <= 1'b1;
      end else begin
         r_rxd_s1 <= uart_rxd;
         r_rxd_s2 <= r_rxd_s1;
         r_rxd_d  <= r_rxd_s2;
      end
   end

   assign w_start_edge = r_rxd_d & ~r_rxd_s2;

   // State register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic and sample strobe; START samples mid start bit, later states one bit apart.
   always_comb begin
      w_next   = r_state;
      w_sample = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start_edge) begin
               w_next = START;
            end else begin
               w_next = IDLE;
            end
         end
         START: begin
            if (r_clk_cnt == CW'(HALF - 1)) begin
               w_sample = 1'b1;
               w_next   = r_rxd_s2 ? IDLE : DATA;
            end else begin
               w_next = START;
            end
         end
         DATA: begin
            if (r_clk_cnt == CW'(BAUD_CNT - 1)) begin
               w_sample = 1'b1;
               w_next   = (r_bit_cnt == 3'd7) ? STOP : DATA;
            end else begin
               w_next = DATA;
            end
         end
         STOP: begin
            if (r_clk_cnt == CW'(BAUD_CNT - 1)) begin
               w_sample = 1'b1;
               w_next   = IDLE;
            end else begin
               w_next = STOP;
            end
         end
         default: begin
            w_next   = IDLE;
            w_sample = 1'b0;
         end
      endcase
   end

   // Baud counter, bit counter and byte shift register.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_clk_cnt <= {CW{1'b0}};
         r_bit_cnt <= 3'd0;
         r_rx_byte <= 8'd0;
      end else begin
         if (r_state == IDLE || w_sample || w_next != r_state) begin
            r_clk_cnt <= {CW{1'b0}};
         end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
         end
         if (r_state == START && w_next == DATA) begin
            r_bit_cnt <= 3'd0;
         end else if (r_state == DATA && w_sample) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (r_state == DATA && w_sample) begin
            r_rx_byte <= {r_rxd_s2, r_rx_byte[7:1]};
         end
      end
   end

   assign w_stop_ok   = (r_state == STOP) && w_sample &&  r_rxd_s2;
   assign w_stop_bad  = (r_state == STOP) && w_sample && !r_rxd_s2;
   assign w_last_byte = (r_byte_cnt == BW'(BYTES - 1));

   if (BYTES == 1) begin : g_one_byte
      assign w_word_next = r_rx_byte;
   end else begin : g_multi_byte
      assign w_word_next = {r_rx_byte, r_word_sr[WW-1:8]};
   end

   // Word assembly and the done / framing-error pulses; a bad stop or timeout drops the partial word.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_word_sr  <= {WW{1'b0}};
         r_byte_cnt <= {BW{1'b0}};
         r_data     <= {WW{1'b0}};
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else if (w_stop_ok) begin
         r_word_sr <= w_word_next;
         r_err     <= 1'b0;
         if (w_last_byte) begin
            r_byte_cnt <= {BW{1'b0}};
            r_data     <= w_word_next;
            r_done     <= 1'b1;
         end else begin
            r_byte_cnt <= r_byte_cnt + BW'(1);
            r_done     <= 1'b0;
         end
      end else if (w_stop_bad) begin
         r_byte_cnt <= {BW{1'b0}};
         r_done     <= 1'b0;
         r_err      <= 1'b1;
      end else if (w_timeout) begin
         r_byte_cnt <= {BW{1'b0}};
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   localparam int TO_MAX = TIMEOUT_BITS * BAUD_CNT - 1;
   localparam int TOW    = (TO_MAX > 0) ? $clog2(TO_MAX + 1) : 1;

   logic [TOW-1:0] r_idle_cnt;
   logic           r_timeout;

   assign w_timeout = (r_state == IDLE) && (r_byte_cnt != {BW{1'b0}}) &&
                      (r_idle_cnt == TOW'(TO_MAX));

   // Idle counter runs only while a partial word is waiting for its next byte.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_idle_cnt <= {TOW{1'b0}};
         r_timeout  <= 1'b0;
      end else begin
         if (r_state == IDLE && r_byte_cnt != {BW{1'b0}} && !w_timeout) begin
            r_idle_cnt <= r_idle_cnt + TOW'(1);
         end else begin
            r_idle_cnt <= {TOW{1'b0}};
         end
         r_timeout <= w_timeout;
      end
   end

   assign uart_bytes_timeout = r_timeout;
`else
   assign w_timeout = 1'b0;
`endif

   assign uart_bytes_data = r_data;
   assign uart_bytes_done = r_done;
   assign uart_frame_err  = r_err;

endmodule

// File: tb/tb_uart_bytes_rx.sv
// Self-checking bench for uart_bytes_rx: table-driven word vectors plus hand-written corner sequences.
module tb_uart_bytes_rx;

   logic        clk;
   logic        rst_n;
   logic        rxd;
   logic [31:0] data;
   logic        done;
   logic        ferr;
`ifdef UART_RX_TIMEOUT_EN
   logic        tmo;
`endif

   uart_bytes_rx #(
      .BYTES   (4),
      .BPS     (5_000_000),
      .CLK_FRE (50_000_000)
   ) dut (
      .sys_clk            (clk),
      .sys_rst_n          (rst_n),
      .uart_rxd           (rxd),
      .uart_bytes_data    (data),
      .uart_bytes_done    (done),
`ifdef UART_RX_TIMEOUT_EN
      .uart_bytes_timeout (tmo),
`endif
      .uart_frame_err     (ferr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_pass  = 0;
   int          done_cnt = 0;
   int          err_cnt  = 0;
   int          tmo_cnt  = 0;
   int          overlap  = 0;
   logic [31:0] cap [$];

   // Pulse monitor, sampled on the inactive edge.
   always @(negedge clk) begin
      if (done) begin
         done_cnt = done_cnt + 1;
         cap.push_back(data);
      end
      if (ferr) err_cnt = err_cnt + 1;
      if (done && ferr) overlap = overlap + 1;
`ifdef UART_RX_TIMEOUT_EN
      if (tmo) tmo_cnt = tmo_cnt + 1;
`endif
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total = n_total + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int k = 0; k < 100; k++) begin
         rxd = fr[k / 10];
         @(negedge clk);
      end
      rxd = 1'b1;
      repeat (gap) @(negedge clk);
   endtask

   typedef struct {
      logic [63:0] b;
      int          n;
      int          bad;
      int          gap;
      int          exp_done;
      int          exp_err;
      logic [31:0] exp_first;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [5];

   initial begin
      int d0, e0, lat;
      logic [9:0] fr;

      vecs[0] = '{64'h00000000_ABCD1234, 4, -1, 3, 1, 0, 32'hABCD1234, 32'hABCD1234};
      vecs[1] = '{64'h00000000_01020304, 4, -1, 2, 1, 0, 32'h01020304, 32'h01020304};
      vecs[2] = '{64'h00000000_00006655, 2,  1, 5, 0, 1, 32'h00000000, 32'h01020304};
      vecs[3] = '{64'h00000000_44332211, 4, -1, 1, 1, 0, 32'h44332211, 32'h44332211};
      vecs[4] = '{64'h07060504_03020100, 8, -1, 0, 2, 0, 32'h03020100, 32'h07060504};

      rst_n = 1'b0;
      rxd   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_data", data, 64'h0);
      check("reset_done", done, 64'h0);
      check("reset_ferr", ferr, 64'h0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            // Short low glitch must be rejected at the mid-start sample.
            d0 = done_cnt; e0 = err_cnt;
            rxd = 1'b0;
            repeat (3) @(negedge clk);
            rxd = 1'b1;
            repeat (30) @(negedge clk);
            check("glitch_pulses", (done_cnt - d0) + (err_cnt - e0), 64'd0);
         end
         d0 = done_cnt; e0 = err_cnt;
         cap.delete();
         for (int f = 0; f < vecs[i].n; f++)
            send_frame(vecs[i].b[8*f +: 8], (f == vecs[i].bad) ? 1'b0 : 1'b1, vecs[i].gap);
         rxd = 1'b1;
         repeat (30) @(negedge clk);
         check($sformatf("v%0d_done_cnt", i), done_cnt - d0, vecs[i].exp_done);
         check($sformatf("v%0d_err_cnt", i), err_cnt - e0, vecs[i].exp_err);
         check($sformatf("v%0d_data", i), data, vecs[i].exp_data);
         if (vecs[i].exp_done > 0 && cap.size() > 0)
            check($sformatf("v%0d_first_word", i), cap[0], vecs[i].exp_first);
         else if (vecs[i].exp_done > 0)
            check($sformatf("v%0d_first_word_missing", i), 64'd0, 64'd1);
      end

      // Done latency: pulse seen on the 98th falling edge after the last frame's start bit begins.
      cap.delete();
      send_frame(8'hA0, 1'b1, 2);
      send_frame(8'hA1, 1'b1, 2);
      send_frame(8'hA2, 1'b1, 2);
      fr  = {1'b1, 8'hA3, 1'b0};
      lat = -1;
      for (int k = 0; k < 100; k++) begin
         rxd = fr[k / 10];
         @(negedge clk);
         if (done && lat < 0) lat = k + 1;
      end
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      check("done_latency", lat, 64'd98);
      check("latency_word", data, 64'hA3A2A1A0);

      // Reset during DATA of the third byte discards the partial word.
      send_frame(8'h11, 1'b1, 1);
      send_frame(8'h22, 1'b1, 1);
      fr = {1'b1, 8'h33, 1'b0};
      for (int k = 0; k < 45; k++) begin
         rxd = fr[k / 10];
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check("midrst_data", data, 64'h0);
      check("midrst_done", done, 64'h0);
      check("midrst_ferr", ferr, 64'h0);
      rxd = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      d0 = done_cnt;
      send_frame(8'hEF, 1'b1, 2);
      send_frame(8'hBE, 1'b1, 2);
      send_frame(8'hAD, 1'b1, 2);
      send_frame(8'hDE, 1'b1, 2);
      repeat (30) @(negedge clk);
      check("postrst_done_cnt", done_cnt - d0, 64'd1);
      check("postrst_data", data, 64'hDEADBEEF);

`ifdef UART_RX_TIMEOUT_EN
      begin
         int t0, tpos;
         d0 = done_cnt; t0 = tmo_cnt; tpos = -1;
         send_frame(8'h55, 1'b1, 0);
         fr = {1'b1, 8'h66, 1'b0};
         for (int k = 0; k < 350; k++) begin
            rxd = (k < 100) ? fr[k / 10] : 1'b1;
            @(negedge clk);
            if (tmo && tpos < 0) tpos = k + 1;
         end
         check("tmo_count", tmo_cnt - t0, 64'd1);
         check("tmo_window", (tpos >= 290 && tpos <= 310) ? 1 : 0, 64'd1);
         check("tmo_no_done", done_cnt - d0, 64'd0);
         check("tmo_data_kept", data, 64'hDEADBEEF);
         send_frame(8'hA1, 1'b1, 2);
         send_frame(8'hB2, 1'b1, 2);
         send_frame(8'hC3, 1'b1, 2);
         send_frame(8'hD4, 1'b1, 2);
         repeat (30) @(negedge clk);
         check("tmo_next_data", data, 64'hD4C3B2A1);
      end
`endif

      check("done_err_overlap", overlap, 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
